// File: rtl/lpm_stream_pkg.sv
// Shared definitions for the ROM streamer: FSM state encoding and ROM read latency.
package lpm_stream_pkg;

    // Cycles from a read being issued to its data on rom_q
    localparam int unsigned ROM_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/lpm_stream_fifo.sv
// Output buffer for the ROM streamer: shift-register FIFO whose head entry is a
// flop, so dout/empty come straight from registers.
// Ports: clock, sclr_n (sync active-low reset), push/din (write), pop (read head),
//        dout (head word), full, empty, count (occupancy).
module lpm_stream_fifo #(
    parameter  int unsigned WIDTH = 9,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             sclr_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem   [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_d;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    wr_idx;
    logic             pop_ok;
    logic             push_ok;

    // A pop frees the head slot, so a push into a full FIFO is accepted in the same cycle
    assign pop_ok  = pop & vld[0];
    assign push_ok = push & (~vld[DEPTH-1] | pop_ok);
    assign wr_idx  = count - CW'(pop_ok);

    // Next contents: shift down on pop, then write at the first free slot
    always_comb begin
        vld_d = vld;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem[i];
        end
        if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem[i+1];
                vld_d[i] = vld[i+1];
            end
            mem_d[DEPTH-1] = '0;
            vld_d[DEPTH-1] = 1'b0;
        end
        if (push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    mem_d[i] = din;
                    vld_d[i] = 1'b1;
                end
            end
        end
        count_d = count + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            vld   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            vld   <= vld_d;
            count <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_d[i];
            end
        end
    end

    assign dout  = mem[0];
    assign empty = ~vld[0];
    assign full  = vld[DEPTH-1];

endmodule

// File: rtl/lpm_rom_streamer.sv
// Streams a burst of consecutive ROM words (address wraps at LPM_NUMWORDS) out of a
// ready/valid port. Reads are issued against a ROM with 2-cycle latency only while
// the output buffer has room for every in-flight word.
// Ports: clock, sclr_n (sync active-low reset), start/start_addr/length (burst
//        request), rom_address/rom_memenab/rom_q (ROM side), dout/dout_valid/
//        dout_ready/dout_last (stream), busy, done (completion pulse).
module lpm_rom_streamer
    import lpm_stream_pkg::*;
#(
    parameter int unsigned LPM_WIDTH    = 8,
    parameter int unsigned LPM_WIDTHAD  = 8,
    parameter int unsigned LPM_NUMWORDS = 1 << LPM_WIDTHAD,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                   clock,
    input  logic                   sclr_n,
    input  logic                   start,
    input  logic [LPM_WIDTHAD-1:0] start_addr,
    input  logic [LPM_WIDTHAD:0]   length,
    output logic [LPM_WIDTHAD-1:0] rom_address,
    output logic                   rom_memenab,
    input  logic [LPM_WIDTH-1:0]   rom_q,
    output logic [LPM_WIDTH-1:0]   dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   dout_last,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned AW = LPM_WIDTHAD;
    localparam int unsigned LW = LPM_WIDTHAD + 1;
    localparam int unsigned FW = LPM_WIDTH + 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    state_t                 state, state_d;
    logic [AW-1:0]          addr, addr_d, addr_inc;
    logic [LW-1:0]          rem, rem_d;
    logic [AW-1:0]          rom_address_d;
    logic                   busy_d;
    logic                   done_d;
    logic [ROM_LATENCY-1:0] pipe_v, pipe_v_d;
    logic [ROM_LATENCY-1:0] pipe_last, pipe_last_d;
    logic                   issue;
    logic                   last_tag;
    logic                   credit;
    logic [OW-1:0]          occ;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [FW-1:0]          fifo_q;

    lpm_stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .sclr_n (sclr_n),
        .push   (pipe_v[ROM_LATENCY-1]),
        .din    ({pipe_last[ROM_LATENCY-1], rom_q}),
        .pop    (pop),
        .dout   (fifo_q),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign dout       = fifo_q[LPM_WIDTH-1:0];
    assign dout_last  = fifo_q[LPM_WIDTH];
    assign dout_valid = ~fifo_empty;
    assign pop        = dout_valid & dout_ready;
    assign addr_inc   = (addr == AW'(LPM_NUMWORDS - 1)) ? '0 : addr + AW'(1);

    // Next-state and next register values
    always_comb begin
        state_d       = state;
        addr_d        = addr;
        rem_d         = rem;
        rom_address_d = rom_address;
        done_d        = 1'b0;
        issue         = 1'b0;
        last_tag      = 1'b0;

        // Buffered plus in-flight words; a pop this cycle frees one slot
        occ = OW'(fifo_count);
        for (int i = 0; i < ROM_LATENCY; i++) begin
            occ = occ + OW'(pipe_v[i]);
        end
        credit = (~fifo_full | pop) && (occ < OW'(FIFO_DEPTH) + OW'(pop));

        unique case (state)
            IDLE: begin
                if (start && (length != '0)) begin
                    addr_d  = start_addr;
                    rem_d   = length;
                    state_d = ISSUE;
                end else if (start) begin
                    done_d = 1'b1;
                end
            end
            ISSUE: begin
                if (credit) begin
                    issue         = 1'b1;
                    rom_address_d = addr;
                    addr_d        = addr_inc;
                    rem_d         = rem - LW'(1);
                    last_tag      = (rem == LW'(1));
                    if (rem == LW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && dout_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        pipe_v_d    = {pipe_v[ROM_LATENCY-2:0], issue};
        pipe_last_d = {pipe_last[ROM_LATENCY-2:0], last_tag};
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            state       <= IDLE;
            addr        <= '0;
            rem         <= '0;
            rom_address <= '0;
            rom_memenab <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pipe_v      <= '0;
            pipe_last   <= '0;
        end else begin
            state       <= state_d;
            addr        <= addr_d;
            rem         <= rem_d;
            rom_address <= rom_address_d;
            rom_memenab <= busy_d;
            busy        <= busy_d;
            done        <= done_d;
            pipe_v      <= pipe_v_d;
            pipe_last   <= pipe_last_d;
        end
    end

endmodule

// File: tb/tb_lpm_rom_streamer.sv
// Self-checking bench for lpm_rom_streamer: directed bursts, expected words queued
// by the driver and compared by an independent output monitor.
module tb_lpm_rom_streamer;

    localparam int unsigned AW    = 8;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic          clock = 1'b0;
    logic          sclr_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic [AW-1:0] rom_address;
    logic          rom_memenab;
    logic [DW-1:0] rom_q = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;
    int n_xfer = 0;
    int n_done = 0;
    int max_occ = 0;
    bit mon_en = 1'b0;
    bit zl_req = 1'b0;
    bit pend_done = 1'b0;
    bit hold = 1'b0;
    logic [DW:0] hold_word = '0;
    logic [DW:0] exp_q[$];

    always #5 clock = ~clock;

    lpm_rom_streamer #(
        .LPM_WIDTH    (DW),
        .LPM_WIDTHAD  (AW),
        .LPM_NUMWORDS (256),
        .FIFO_DEPTH   (DEPTH)
    ) u_dut (
        .clock       (clock),
        .sclr_n      (sclr_n),
        .start       (start),
        .start_addr  (start_addr),
        .length      (length),
        .rom_address (rom_address),
        .rom_memenab (rom_memenab),
        .rom_q       (rom_q),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
        .busy        (busy),
        .done        (done)
    );

    function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
        return (a * 8'd37) ^ 8'h5A;
    endfunction

    // ROM output register; rom_address acts as the ROM's address register
    always @(posedge clock) begin
        if (rom_memenab) rom_q <= rom_val(rom_address);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard pops, hold-stability and done-pulse timing
    always @(negedge clock) begin
        if (mon_en) begin
            check("done_pulse", 32'(done), 32'(pend_done));
            pend_done = 1'b0;
            if (zl_req) begin
                pend_done = 1'b1;
                zl_req    = 1'b0;
            end
            if (done) n_done++;
            if (int'(u_dut.u_fifo.count) > max_occ) max_occ = int'(u_dut.u_fifo.count);
            if (!sclr_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 32'(dout_valid), 32'd1);
                    check("hold_word", 32'({dout_last, dout}), 32'(hold_word));
                end
                hold      = dout_valid && !dout_ready;
                hold_word = {dout_last, dout};
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: got 0x%0h expected none", {dout_last, dout});
                    end else begin
                        check("word", 32'({dout_last, dout}), 32'(exp_q.pop_front()));
                    end
                    if (dout_last) pend_done = 1'b1;
                    n_xfer++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_burst(input logic [AW-1:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), rom_val(AW'(32'(a) + 32'(i)))});
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] a, input int n);
        start_addr = a;
        length     = LW'(n);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string name, input bit toggle);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 3000) begin
            if (toggle) dout_ready = ~dout_ready;
            tick();
            k++;
        end
        if (k >= 3000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
        dout_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_valid"}, 32'(dout_valid), 32'd0);
        check({name, "_dout"}, 32'(dout), 32'd0);
        check({name, "_last"}, 32'(dout_last), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_addr"}, 32'(rom_address), 32'd0);
        check({name, "_memenab"}, 32'(rom_memenab), 32'd0);
    endtask

    initial begin
        int d0;
        int x0;
        int k;

        sclr_n     = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        dout_ready = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        sclr_n = 1'b1;
        mon_en = 1'b1;
        tick();

        // Basic burst: latency, back-to-back words, done one cycle after last
        d0 = n_done;
        expect_burst(8'h10, 4);
        pulse_start(8'h10, 4);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_memenab", 32'(rom_memenab), 32'd1);
        k = 0;
        while (!dout_valid && k < 20) begin
            tick();
            k++;
        end
        check("first_latency", 32'(k), 32'd3);
        for (int i = 0; i < 4; i++) begin
            check("basic_consecutive", 32'(dout_valid), 32'd1);
            tick();
        end
        check("basic_done", 32'(done), 32'd1);
        check("basic_busy_end", 32'(busy), 32'd0);
        wait_idle("basic", 1'b0);
        check("basic_done_count", 32'(n_done - d0), 32'd1);

        // Backpressure with ready toggling every cycle
        d0 = n_done;
        max_occ = 0;
        expect_burst(8'h30, 8);
        pulse_start(8'h30, 8);
        wait_idle("backpressure", 1'b1);
        check("bp_done_count", 32'(n_done - d0), 32'd1);
        check("bp_max_buffered", 32'(max_occ <= int'(DEPTH)), 32'd1);

        // Address wrap FE, FF, 00, 01
        d0 = n_done;
        expect_burst(8'hFE, 4);
        pulse_start(8'hFE, 4);
        wait_idle("wrap", 1'b0);
        check("wrap_done_count", 32'(n_done - d0), 32'd1);

        // Length longer than the ROM wraps repeatedly
        d0 = n_done;
        x0 = n_xfer;
        expect_burst(8'hF0, 300);
        pulse_start(8'hF0, 300);
        wait_idle("longwrap", 1'b0);
        check("longwrap_count", 32'(n_xfer - x0), 32'd300);
        check("longwrap_done_count", 32'(n_done - d0), 32'd1);

        // Zero length: done next cycle, nothing else moves
        d0 = n_done;
        zl_req = 1'b1;
        pulse_start(8'h55, 0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_valid", 32'(dout_valid), 32'd0);
        tick();
        check("zero_done_clear", 32'(done), 32'd0);
        check("zero_busy2", 32'(busy), 32'd0);
        check("zero_valid2", 32'(dout_valid), 32'd0);
        tick();
        check("zero_done_count", 32'(n_done - d0), 32'd1);

        // Reset after two words of a ten-word burst, then a fresh burst
        x0 = n_xfer;
        expect_burst(8'h20, 10);
        pulse_start(8'h20, 10);
        k = 0;
        while (n_xfer < x0 + 2 && k < 50) begin
            tick();
            k++;
        end
        check("rst_mid_two_words", 32'(n_xfer - x0), 32'd2);
        sclr_n = 1'b0;
        exp_q.delete();
        tick();
        sclr_n = 1'b1;
        check_idle_outputs("rst_mid");
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_no_stale", 32'(dout_valid), 32'd0);
        end
        d0 = n_done;
        expect_burst(8'h00, 5);
        pulse_start(8'h00, 5);
        wait_idle("after_reset", 1'b0);
        check("after_reset_done_count", 32'(n_done - d0), 32'd1);

        // Second start during a burst is ignored
        d0 = n_done;
        x0 = n_xfer;
        expect_burst(8'h40, 6);
        pulse_start(8'h40, 6);
        tick();
        pulse_start(8'h80, 5);
        wait_idle("busy_start", 1'b0);
        check("busy_start_words", 32'(n_xfer - x0), 32'd6);
        check("busy_start_done_count", 32'(n_done - d0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
